// File: rtl/st_swap_pkg.sv
// ============================================================================
// Module : st_swap_pkg
// Brief  : Shared widths, packet-state encoding and beat layout for the
//          channel/data join-and-swap stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package st_swap_pkg;

  localparam int DEF_DATA_W = 5;
  localparam int DEF_CH_W   = 2;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pkt_state_t;

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_CH_W-1:0]   channel;
  } beat_t;

endpackage

`default_nettype wire

// File: rtl/st_skid_buffer.sv
// ============================================================================
// Module : st_skid_buffer
// Brief  : Generic 2-entry valid/ready register slice. Entry 0 drives the
//          output; o_space is purely registered (entry 1 empty).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module st_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_space,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_v0;
  logic         r_v1;
  logic [W-1:0] r_e0;
  logic [W-1:0] r_e1;
  logic         w_pop;

  assign w_pop   = r_v0 & i_ready;
  assign o_space = ~r_v1;
  assign o_valid = r_v0;
  assign o_data  = r_e0;

  // i_valid is only asserted by the caller while o_space is high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_e0 <= '0;
      r_e1 <= '0;
    end else if (!r_v0) begin
      if (i_valid) begin
        r_e0 <= i_data;
        r_v0 <= 1'b1;
      end
    end else if (!r_v1) begin
      if (w_pop && i_valid) begin
        r_e0 <= i_data;
      end else if (w_pop) begin
        r_v0 <= 1'b0;
      end else if (i_valid) begin
        r_e1 <= i_data;
        r_v1 <= 1'b1;
      end
    end else if (w_pop) begin
      r_e0 <= r_e1;
      r_v1 <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/st_ch_data_join_and_swap.sv
// ============================================================================
// Module : st_ch_data_join_and_swap
// Brief  : Joins the payload stream (in its channel field) with the channel
//          stream (in its data field) into one channelised stream, swapping
//          the fields back. Optional framing checker: ST_JOIN_PKT_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module st_ch_data_join_and_swap
  import st_swap_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CH_W   = DEF_CH_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dici_valid,
  output logic              dici_ready,
  input  logic              dici_startofpacket,
  input  logic              dici_endofpacket,
  input  logic [DATA_W-1:0] dici_channel,
  input  logic              cido_valid,
  output logic              cidi_ready,
  input  logic [CH_W-1:0]   cidi_data,
  output logic              STout_valid,
  input  logic              STout_ready,
  output logic              STout_startofpacket,
  output logic              STout_endofpacket,
  output logic [DATA_W-1:0] STout_data,
  output logic [CH_W-1:0]   STout_channel,
  output logic              pkt_err
);

  logic  r_rdy_en;
  logic  w_skid_space;
  logic  w_space;
  logic  w_join;
  beat_t w_in_beat;
  beat_t w_out_beat;

  // Holds the readies low for the first cycle out of reset
  always_ff @(posedge clk) begin
    if (reset) r_rdy_en <= 1'b0;
    else       r_rdy_en <= 1'b1;
  end

  assign w_space    = r_rdy_en & w_skid_space & ~reset;
  assign dici_ready = w_space & cido_valid;
  assign cidi_ready = w_space & dici_valid;
  assign w_join     = dici_valid & cido_valid & w_space;

  always_comb begin
    w_in_beat         = '0;
    w_in_beat.sop     = dici_startofpacket;
    w_in_beat.eop     = dici_endofpacket;
    w_in_beat.data    = dici_channel;
    w_in_beat.channel = cidi_data;
  end

  st_skid_buffer #(
    .W ($bits(beat_t))
  ) u_skid (
    .clk     (clk),
    .rst     (reset),
    .i_valid (w_join),
    .i_data  (w_in_beat),
    .o_space (w_skid_space),
    .o_valid (STout_valid),
    .i_ready (STout_ready),
    .o_data  (w_out_beat)
  );

  assign STout_startofpacket = w_out_beat.sop;
  assign STout_endofpacket   = w_out_beat.eop;
  assign STout_data          = w_out_beat.data;
  assign STout_channel       = w_out_beat.channel;

`ifdef ST_JOIN_PKT_CHECK_EN
  pkt_state_t r_state;
  pkt_state_t w_state_nxt;
  logic       r_pkt_err;
  logic       w_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pkt_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pkt_err <= r_pkt_err | w_bad;
    end
  end

  // A bad beat is flagged but framing still tracks its SOP/EOP
  always_comb begin
    w_state_nxt = r_state;
    w_bad       = 1'b0;
    if (w_join) begin
      case (r_state)
        IDLE: begin
          w_bad       = ~dici_startofpacket;
          w_state_nxt = dici_endofpacket ? IDLE : IN_PKT;
        end
        IN_PKT: begin
          w_bad = dici_startofpacket;
          if (dici_endofpacket) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign pkt_err = r_pkt_err;
`else
  assign pkt_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_st_ch_data_join_and_swap.sv
// ============================================================================
// Module : tb_st_ch_data_join_and_swap
// Brief  : Self-checking bench: directed and random stimulus against a
//          queue-based reference of the join/swap stream.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_st_ch_data_join_and_swap;

  logic       clk = 1'b0;
  logic       reset;
  logic       dici_valid, dici_ready, dici_startofpacket, dici_endofpacket;
  logic [4:0] dici_channel;
  logic       cido_valid, cidi_ready;
  logic [1:0] cidi_data;
  logic       STout_valid, STout_ready, STout_startofpacket, STout_endofpacket;
  logic [4:0] STout_data;
  logic [1:0] STout_channel;
  logic       pkt_err;

  always #5 clk = ~clk;

  st_ch_data_join_and_swap #(.DATA_W(5), .CH_W(2)) dut (
    .clk                 (clk),
    .reset               (reset),
    .dici_valid          (dici_valid),
    .dici_ready          (dici_ready),
    .dici_startofpacket  (dici_startofpacket),
    .dici_endofpacket    (dici_endofpacket),
    .dici_channel        (dici_channel),
    .cido_valid          (cido_valid),
    .cidi_ready          (cidi_ready),
    .cidi_data           (cidi_data),
    .STout_valid         (STout_valid),
    .STout_ready         (STout_ready),
    .STout_startofpacket (STout_startofpacket),
    .STout_endofpacket   (STout_endofpacket),
    .STout_data          (STout_data),
    .STout_channel       (STout_channel),
    .pkt_err             (pkt_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a two-deep in-order store with an accept rule and framing rules
  typedef struct {
    logic       sop;
    logic       eop;
    logic [4:0] data;
    logic [1:0] channel;
  } mbeat_t;

  mbeat_t q[$];
  bit     m_en    = 1'b0;
  bit     m_zero  = 1'b0;
  bit     m_inpkt = 1'b0;
  bit     m_err   = 1'b0;
  bit     m_join  = 1'b0;

  task automatic cycle();
    bit     sp;
    bit     pop;
    mbeat_t b;
    @(negedge clk);
    sp = m_en && (q.size() < 2) && !reset;
    check("dici_ready", dici_ready, sp && cido_valid);
    check("cidi_ready", cidi_ready, sp && dici_valid);
    check("STout_valid", STout_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("STout_data", STout_data, q[0].data);
      check("STout_channel", STout_channel, q[0].channel);
      check("STout_sop", STout_startofpacket, q[0].sop);
      check("STout_eop", STout_endofpacket, q[0].eop);
    end else if (m_zero) begin
      check("idle_fields", {STout_startofpacket, STout_endofpacket, STout_data, STout_channel}, 0);
    end
    check("pkt_err", pkt_err, m_err);
    m_join    = dici_valid && cido_valid && sp;
    pop       = (q.size() > 0) && STout_ready;
    b.sop     = dici_startofpacket;
    b.eop     = dici_endofpacket;
    b.data    = dici_channel;
    b.channel = cidi_data;
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_en    = 1'b0;
      m_zero  = 1'b1;
      m_inpkt = 1'b0;
      m_err   = 1'b0;
      m_join  = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (m_join) begin
        q.push_back(b);
        m_zero = 1'b0;
`ifdef ST_JOIN_PKT_CHECK_EN
        if (!m_inpkt && !b.sop) m_err = 1'b1;
        if (m_inpkt && b.sop)   m_err = 1'b1;
        m_inpkt = !b.eop;
`endif
      end
      m_en = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    dici_valid = 1'b0;
    cido_valid = 1'b0;
  endtask

  task automatic send(input bit s, input bit e, input logic [4:0] d, input logic [1:0] c);
    dici_valid = 1'b1; cido_valid = 1'b1;
    dici_startofpacket = s; dici_endofpacket = e;
    dici_channel = d; cidi_data = c;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (m_join) break;
    end
    if (!m_join) check("send_timeout", 0, 1);
    idle_inputs();
  endtask

  task automatic stream(input bit bp);
    int idx = 0;
    int cyc = 0;
    while (idx < 32 && cyc < 200) begin
      dici_valid = 1'b1; cido_valid = 1'b1;
      dici_startofpacket = 1'b1; dici_endofpacket = 1'b1;
      dici_channel = idx[4:0];
      cidi_data    = idx[1:0];
      STout_ready  = !(bp && cyc >= 8 && cyc < 13);
      cycle();
      if (m_join) idx++;
      cyc++;
    end
    if (idx < 32) check("stream_timeout", idx, 32);
    idle_inputs();
    STout_ready = 1'b1;
    repeat (4) cycle();
  endtask

  initial begin
    reset = 1'b1; STout_ready = 1'b1;
    dici_startofpacket = 1'b0; dici_endofpacket = 1'b0;
    dici_channel = '0; cidi_data = '0;
    idle_inputs();
    repeat (2) cycle();
    reset = 1'b0;
    repeat (2) cycle();

    stream(1'b0);
    stream(1'b1);

    // Lone valid on the payload side: nothing may be consumed
    dici_valid = 1'b1; dici_startofpacket = 1'b1; dici_endofpacket = 1'b1;
    dici_channel = 5'h15; cidi_data = 2'd2;
    repeat (10) begin
      cycle();
      check("lone_no_join", m_join, 0);
    end
    send(1'b1, 1'b1, 5'h15, 2'd2);
    repeat (3) cycle();

    // Random traffic with random backpressure and framing
    for (int i = 0; i < 400; i++) begin
      dici_valid         = ($urandom_range(0, 3) != 0);
      cido_valid         = ($urandom_range(0, 3) != 0);
      STout_ready        = ($urandom_range(0, 2) != 0);
      dici_startofpacket = $urandom_range(0, 1);
      dici_endofpacket   = $urandom_range(0, 1);
      dici_channel       = 5'($urandom);
      cidi_data          = 2'($urandom);
      cycle();
    end
    idle_inputs(); STout_ready = 1'b1;
    repeat (3) cycle();

    // Fill the skid under backpressure, then reset mid-stream
    STout_ready = 1'b0;
    dici_valid = 1'b1; cido_valid = 1'b1;
    for (int k = 0; k < 10 && q.size() < 2; k++) cycle();
    check("skid_full", q.size(), 2);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    check("post_reset_valid", STout_valid, 0);
    cycle();
    STout_ready = 1'b1;
    idle_inputs();
    repeat (3) cycle();

    // Framing: SOP, middle, EOP, then a beat without SOP
    send(1'b1, 1'b0, 5'h01, 2'd1);
    send(1'b0, 1'b0, 5'h02, 2'd1);
    send(1'b0, 1'b1, 5'h03, 2'd1);
    cycle();
    check("pkt_err_clean", pkt_err, 0);
    send(1'b0, 1'b1, 5'h04, 2'd3);
    repeat (5) cycle();
`ifdef ST_JOIN_PKT_CHECK_EN
    check("pkt_err_sticky", pkt_err, 1);
`else
    check("pkt_err_off", pkt_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
